// File: rtl/stack_multi.sv
// stack_multi: parametrised stack with signed multi-step SP delta, NOS read port, occupancy and sticky error flags
//   clk, reset (sync, active-high), wait_state (freeze), D (write data), delta (signed SP step),
//   update (write D at new SP), clear_err (clear sticky flags)
//   Q (TOS), Q1 (NOS), depth (0..DEPTH), empty, full, overflow, underflow
//   Optional macro STACK_GUARD_EN: out-of-range operations are suppressed (SP/depth hold, no write).
module stack_multi #(
  parameter int saddr_width = 8,
  parameter int width       = 16,
  parameter int delta_width = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wait_state,
  input  logic [width-1:0]       D,
  input  logic [delta_width-1:0] delta,
  input  logic                   update,
  input  logic                   clear_err,
  output logic [width-1:0]       Q,
  output logic [width-1:0]       Q1,
  output logic [saddr_width:0]   depth,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int DEPTH = 2**saddr_width;
  localparam logic [saddr_width:0] DMAX = (saddr_width+1)'(DEPTH);
  logic [width-1:0] mem_q [DEPTH];
  logic [saddr_width-1:0] sp_q, sp_d, sp_sum, nos_a;
  logic [saddr_width:0] depth_q, depth_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic signed [saddr_width+1:0] dext, depth_raw;
  logic ovf_hit, unf_hit, err, we;
  always_comb begin
    dext      = (saddr_width+2)'(signed'(delta));
    depth_raw = signed'({1'b0, depth_q}) + dext;
    sp_sum    = sp_q + dext[saddr_width-1:0];
    ovf_hit   = depth_raw > signed'({1'b0, DMAX});
    unf_hit   = depth_raw[saddr_width+1];
    err       = ovf_hit | unf_hit;
`ifdef STACK_GUARD_EN
    sp_d      = err ? sp_q : sp_sum;
    we        = update & ~err;
    depth_d   = err ? depth_q : depth_raw[saddr_width:0];
`else
    sp_d      = sp_sum;
    we        = update;
    depth_d   = ovf_hit ? DMAX : unf_hit ? '0 : depth_raw[saddr_width:0];
`endif
    // a fresh error beats clear_err; each flag is cleared independently
    ovf_d     = ovf_hit | (ovf_q & ~clear_err);
    unf_d     = unf_hit | (unf_q & ~clear_err);
    nos_a     = sp_q - saddr_width'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!wait_state) begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // write lands at the new SP so a push-with-update becomes the new TOS
  always_ff @(posedge clk) begin
    if (!reset && !wait_state && we) mem_q[sp_d] <= D;
  end
  assign Q         = mem_q[sp_q];
  assign Q1        = mem_q[nos_a];
  assign depth     = depth_q;
  assign empty     = depth_q == '0;
  assign full      = depth_q == DMAX;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`ifdef FORMAL
  always_ff @(posedge clk) begin
    assert (depth_q <= DMAX);
    if (!reset && !wait_state && !err)
      assert ((sp_d - depth_d[saddr_width-1:0]) == (sp_q - depth_q[saddr_width-1:0]));
  end
`endif
endmodule
